uart_tx_fifo: RTL

- Serial UART transmitter, 8N1 framing, with a byte FIFO on its parallel side.
- Sits between the I/O controller and the TX pin; consumes the controller's byte + ready strobe.
- Absorbs bursts such as a back-to-back 15-byte "Hello, world!\r\n" so no byte is dropped while the line is busy.
- Serialises bytes LSB first at a fixed baud rate.

---
 rtl/uart_tx_fifo.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
// uart_tx_fifo: byte FIFO feeding an 8N1 UART serialiser (LSB first).
// Optional build macro UART_TX_PARITY_EN inserts an even-parity bit (8E1).
module uart_tx_fifo #(
    parameter int unsigned CLK_FREQ = 100000000,
    parameter int unsigned BAUD     = 115200,
    parameter int unsigned FIFO_AW  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_rdy,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       ovf,
    output logic       tx
);

    localparam int unsigned DIV   = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam int unsigned CW    = FIFO_AW + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [CW-1:0]      count;
    logic [CW-1:0]      count_nxt;
    logic               pop_c;
    logic               wr_c;
    logic               drop_c;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               bit_end_c;
    logic [2:0]         bit_idx;
    logic [7:0]         shift;
`ifdef UART_TX_PARITY_EN
    logic               par;
`endif

    // FIFO handshake: a pop in IDLE frees a slot, so a write is taken even when full
    assign pop_c  = (state == IDLE) && !empty;
    assign wr_c   = din_rdy && (!full || pop_c);
    assign drop_c = din_rdy && full && !pop_c;

    // Occupancy after this edge
    always_comb begin
        count_nxt = count;
        case ({wr_c, pop_c})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // FIFO storage (no reset needed on the data array)
    always_ff @(posedge clk) begin
        if (wr_c) begin
            mem[wr_ptr] <= din;
        end
    end

    // FIFO pointers, occupancy, flags and sticky overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            ovf    <= 1'b0;
        end else begin
            if (wr_c) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
            if (drop_c) begin
                ovf <= 1'b1;
            end
        end
    end

    assign bit_end_c = (cnt == CNT_LAST);

    // Frame sequencer; tx follows the state one clock later so it is a clean register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            if (state != IDLE) begin
                cnt <= bit_end_c ? '0 : cnt + CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (!empty) begin
                        shift   <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                        par     <= ^mem[rd_ptr];
`endif
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= START;
                        busy    <= 1'b1;
                    end
                end
                START: begin
                    tx <= 1'b0;
                    if (bit_end_c) begin
                        state   <= DATA;
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    tx <= shift[0];
                    if (bit_end_c) begin
                        shift   <= {1'b0, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    tx <= par;
                    if (bit_end_c) begin
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    tx <= 1'b1;
                    if (bit_end_c) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
